// File: rtl/riscboy_ppu_busmaster_pkg.sv
// Shared AHB-Lite encodings and size helpers for the PPU bus master.
package riscboy_ppu_busmaster_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Address phase either follows the arbiter or is frozen by a wait state
  typedef enum logic {
    APH_FREE,
    APH_HELD
  } aph_state_t;

  // Low address bits that must be cleared for a naturally aligned transfer
  function automatic logic [1:0] size_align_mask(input logic [1:0] size);
    case ({1'b0, size})
      HSIZE_BYTE: size_align_mask = 2'b00;
      HSIZE_HALF: size_align_mask = 2'b01;
      default:    size_align_mask = 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/riscboy_ppu_rr_arb.sv
// One-hot round-robin arbiter; priority moves past the last granted port on advance.
module riscboy_ppu_rr_arb #(
  parameter int unsigned N     = 4,
  parameter int unsigned W_IDX = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [W_IDX-1:0] grant_idx
);

  logic [W_IDX-1:0] ptr;
  logic [N-1:0]     eligible;

  assign eligible = req & ~mask;

  function automatic logic [W_IDX-1:0] slot(input logic [W_IDX-1:0] p, input int unsigned k);
    return W_IDX'((32'(p) + k) % N);
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (eligible[slot(ptr, k)] && grant == '0) begin
        grant[slot(ptr, k)] = 1'b1;
        grant_idx           = slot(ptr, k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && |grant) begin
      ptr <= (32'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/riscboy_ppu_busmaster.sv
// PPU fetch-port responder: round-robin arbitration onto a pipelined AHB-Lite read master.
module riscboy_ppu_busmaster
  import riscboy_ppu_busmaster_pkg::*;
#(
  parameter int unsigned        N_REQ     = 4,
  parameter int unsigned        W_ADDR    = 32,
  parameter int unsigned        W_DATA    = 32,
  parameter logic [W_ADDR-1:0]  ADDR_MASK = '1,
  parameter int unsigned        W_REQIDX  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_vld,
  input  logic [N_REQ*W_ADDR-1:0] req_addr,
  input  logic [2*N_REQ-1:0]      req_size,
  output logic [N_REQ-1:0]        req_rdy,
  output logic [W_DATA-1:0]       req_data,
  output logic [W_ADDR-1:0]       ahblm_haddr,
  output logic [1:0]              ahblm_htrans,
  output logic [2:0]              ahblm_hsize,
  output logic                    ahblm_hwrite,
  input  logic                    ahblm_hready,
  input  logic                    ahblm_hresp,
  input  logic [W_DATA-1:0]       ahblm_hrdata
);

  logic [W_ADDR-1:0]   port_addr [N_REQ];
  logic [1:0]          port_size [N_REQ];

  aph_state_t          aph_state, aph_state_nxt;
  logic [W_REQIDX-1:0] aph_idx_q;
  logic [W_ADDR-1:0]   aph_addr_q;
  logic [1:0]          aph_size_q;

  logic                dph_vld;
  logic [W_REQIDX-1:0] dph_idx;
  logic [1:0]          dph_size;
  logic [1:0]          dph_lane;
  logic [N_REQ-1:0]    dph_onehot;

  logic [N_REQ-1:0]    arb_req, arb_mask, arb_grant;
  logic [W_REQIDX-1:0] arb_idx;

  logic                issue_vld;
  logic [W_REQIDX-1:0] issue_idx;
  logic [W_ADDR-1:0]   issue_addr;
  logic [1:0]          issue_size;

  logic [W_DATA-1:0]   lane_data, rdata_sized;

  for (genvar g = 0; g < N_REQ; g++) begin : g_port
    logic pending;
    assign port_addr[g] = req_addr[g*W_ADDR +: W_ADDR];
    assign port_size[g] = req_size[g*2 +: 2];
    assign pending = (dph_vld && dph_idx == W_REQIDX'(g)) ||
                     (aph_state == APH_HELD && aph_idx_q == W_REQIDX'(g));
    a_vld_held: assert property (@(posedge clk) disable iff (!rst_n) pending |-> req_vld[g]);
  end

  assign dph_onehot = dph_vld ? (N_REQ'(1) << dph_idx) : '0;

  // While held, the arbiter sees only the locked port so its pointer advances past that port
  assign arb_req  = (aph_state == APH_HELD) ? (N_REQ'(1) << aph_idx_q) : req_vld;
  assign arb_mask = (aph_state == APH_HELD) ? '0 : dph_onehot;

  riscboy_ppu_rr_arb #(
    .N     (N_REQ),
    .W_IDX (W_REQIDX)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (arb_req),
    .mask      (arb_mask),
    .advance   (issue_vld && ahblm_hready),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_comb begin
    aph_state_nxt = aph_state;
    issue_vld     = 1'b0;
    issue_idx     = '0;
    issue_addr    = '0;
    issue_size    = '0;
    if (aph_state == APH_HELD) begin
      issue_vld  = 1'b1;
      issue_idx  = aph_idx_q;
      issue_addr = aph_addr_q;
      issue_size = aph_size_q;
    end else if (|arb_grant) begin
      issue_vld  = 1'b1;
      issue_idx  = arb_idx;
      issue_size = port_size[arb_idx];
      issue_addr = port_addr[arb_idx] & ADDR_MASK &
                   ~W_ADDR'(size_align_mask(port_size[arb_idx]));
    end
    if (issue_vld) begin
      aph_state_nxt = ahblm_hready ? APH_FREE : APH_HELD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aph_state  <= APH_FREE;
      aph_idx_q  <= '0;
      aph_addr_q <= '0;
      aph_size_q <= '0;
      dph_vld    <= 1'b0;
      dph_idx    <= '0;
      dph_size   <= '0;
      dph_lane   <= '0;
    end else begin
      aph_state <= aph_state_nxt;
      if (issue_vld && !ahblm_hready) begin
        aph_idx_q  <= issue_idx;
        aph_addr_q <= issue_addr;
        aph_size_q <= issue_size;
      end
      if (ahblm_hready) begin
        dph_vld <= issue_vld;
        if (issue_vld) begin
          dph_idx  <= issue_idx;
          dph_size <= issue_size;
          dph_lane <= issue_addr[1:0];
        end
      end
    end
  end

  assign lane_data = ahblm_hrdata >> {dph_lane, 3'b000};

  always_comb begin
    case ({1'b0, dph_size})
      HSIZE_BYTE: rdata_sized = {{(W_DATA-8){1'b0}}, lane_data[7:0]};
      HSIZE_HALF: rdata_sized = {{(W_DATA-16){1'b0}}, lane_data[15:0]};
      HSIZE_WORD: rdata_sized = lane_data;
      default:    rdata_sized = lane_data;
    endcase
  end

  assign ahblm_htrans = issue_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahblm_haddr  = issue_addr;
  assign ahblm_hsize  = issue_vld ? {1'b0, issue_size} : HSIZE_BYTE;
  assign ahblm_hwrite = 1'b0;

  // Error completions still strobe rdy so a requester never hangs, but carry zero data
  assign req_rdy  = ahblm_hready ? dph_onehot : '0;
  assign req_data = (dph_vld && ahblm_hready && !ahblm_hresp) ? rdata_sized : '0;

endmodule

// File: tb/tb_riscboy_ppu_busmaster.sv
// Directed scenarios plus a randomized run against a transaction-level reference model.
module tb_riscboy_ppu_busmaster;

  localparam int unsigned N = 4;
  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req_vld;
  logic [127:0]  req_addr;
  logic [7:0]    req_size;
  logic [3:0]    req_rdy;
  logic [31:0]   req_data;
  logic [31:0]   ahblm_haddr;
  logic [1:0]    ahblm_htrans;
  logic [2:0]    ahblm_hsize;
  logic          ahblm_hwrite;
  logic          ahblm_hready;
  logic          ahblm_hresp;
  logic [31:0]   ahblm_hrdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  riscboy_ppu_busmaster #(
    .N_REQ     (4),
    .W_ADDR    (32),
    .W_DATA    (32),
    .ADDR_MASK (32'hFFFF_FFFF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_vld      (req_vld),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_rdy      (req_rdy),
    .req_data     (req_data),
    .ahblm_haddr  (ahblm_haddr),
    .ahblm_htrans (ahblm_htrans),
    .ahblm_hsize  (ahblm_hsize),
    .ahblm_hwrite (ahblm_hwrite),
    .ahblm_hready (ahblm_hready),
    .ahblm_hresp  (ahblm_hresp),
    .ahblm_hrdata (ahblm_hrdata)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] align_addr(input logic [31:0] a, input logic [1:0] size);
    return a - (a % (32'd1 << size));
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [31:0] addr,
                                               input logic [1:0] size);
    int unsigned nbytes, lane;
    logic [63:0] v;
    nbytes = 1 << size;
    lane   = addr % 4;
    v = (64'(word) >> (8 * lane)) % (64'd1 << (8 * nbytes));
    return v[31:0];
  endfunction

  task automatic set_req(input int p, input logic v, input logic [31:0] a, input logic [1:0] s);
    req_vld[p]          = v;
    req_addr[p*32 +: 32] = a;
    req_size[p*2 +: 2]   = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_vld = '0; ahblm_hready = 1'b1; ahblm_hresp = 1'b0; ahblm_hrdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_tests++; if (ahblm_htrans !== T_IDLE) begin n_fail++; $display("FAIL rst_htrans: got %h want %h", ahblm_htrans, T_IDLE); end
    n_tests++; if (ahblm_haddr !== 32'h0) begin n_fail++; $display("FAIL rst_haddr: got %h want 0", ahblm_haddr); end
    n_tests++; if (ahblm_hsize !== 3'd0) begin n_fail++; $display("FAIL rst_hsize: got %h want 0", ahblm_hsize); end
    n_tests++; if (ahblm_hwrite !== 1'b0) begin n_fail++; $display("FAIL rst_hwrite: got %h want 0", ahblm_hwrite); end
    n_tests++; if (req_rdy !== 4'h0) begin n_fail++; $display("FAIL rst_rdy: got %h want 0", req_rdy); end
    n_tests++; if (req_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", req_data); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++; if (req_rdy !== 4'h0 || ahblm_htrans !== T_IDLE) begin
      n_fail++; $display("FAIL post_rst: got rdy %h htrans %h want 0 0", req_rdy, ahblm_htrans);
    end
  endtask

  task automatic test_single_word();
    @(negedge clk);
    set_req(0, 1'b1, 32'h2000_0004, 2'd2); ahblm_hrdata = 32'h0;
    #1;
    n_tests++; if (ahblm_htrans !== T_NSEQ) begin n_fail++; $display("FAIL t1_htrans: got %h want %h", ahblm_htrans, T_NSEQ); end
    n_tests++; if (ahblm_haddr !== 32'h2000_0004) begin n_fail++; $display("FAIL t1_haddr: got %h want 20000004", ahblm_haddr); end
    n_tests++; if (ahblm_hsize !== 3'd2) begin n_fail++; $display("FAIL t1_hsize: got %h want 2", ahblm_hsize); end
    n_tests++; if (req_rdy !== 4'h0) begin n_fail++; $display("FAIL t1_rdy0: got %h want 0", req_rdy); end
    @(negedge clk);
    ahblm_hrdata = 32'hDEAD_BEEF;
    #1;
    n_tests++; if (req_rdy !== 4'b0001) begin n_fail++; $display("FAIL t1_rdy1: got %h want 1", req_rdy); end
    n_tests++; if (req_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL t1_data: got %h want deadbeef", req_data); end
    n_tests++; if (ahblm_htrans !== T_IDLE) begin n_fail++; $display("FAIL t1_masked: got %h want %h", ahblm_htrans, T_IDLE); end
    @(negedge clk);
    req_vld = '0;
  endtask

  task automatic test_byte();
    @(negedge clk);
    set_req(1, 1'b1, 32'h0100_0003, 2'd0);
    #1;
    n_tests++; if (ahblm_hsize !== 3'd0) begin n_fail++; $display("FAIL t2_hsize: got %h want 0", ahblm_hsize); end
    n_tests++; if (ahblm_haddr !== 32'h0100_0003) begin n_fail++; $display("FAIL t2_haddr: got %h want 01000003", ahblm_haddr); end
    @(negedge clk);
    ahblm_hrdata = 32'h1122_3344;
    #1;
    n_tests++; if (req_rdy !== 4'b0010) begin n_fail++; $display("FAIL t2_rdy: got %h want 2", req_rdy); end
    n_tests++; if (req_data !== 32'h0000_0011) begin n_fail++; $display("FAIL t2_data: got %h want 00000011", req_data); end
    @(negedge clk);
    req_vld = '0;
  endtask

  task automatic test_all_four();
    do_reset();
    for (int p = 0; p < 4; p++) set_req(p, 1'b1, 32'h1004 + 32'(p) * 32'h100, 2'd2);
    for (int k = 0; k < 5; k++) begin
      if (k >= 2) req_vld[k-2] = 1'b0;
      ahblm_hrdata = 32'hA5A5_0000 | 32'(k);
      #1;
      if (k < 4) begin
        n_tests++; if (ahblm_htrans !== T_NSEQ || ahblm_haddr !== 32'h1004 + 32'(k) * 32'h100) begin
          n_fail++; $display("FAIL t3_grant%0d: got %h/%h want %h/%h", k, ahblm_htrans, ahblm_haddr, T_NSEQ, 32'h1004 + 32'(k) * 32'h100);
        end
      end else begin
        n_tests++; if (ahblm_htrans !== T_IDLE) begin n_fail++; $display("FAIL t3_idle: got %h want %h", ahblm_htrans, T_IDLE); end
      end
      n_tests++; if (req_rdy !== ((k > 0) ? 4'(1 << (k - 1)) : 4'h0)) begin
        n_fail++; $display("FAIL t3_rdy%0d: got %h want %h", k, req_rdy, (k > 0) ? 4'(1 << (k - 1)) : 4'h0);
      end
      if (k > 0) begin
        n_tests++; if (req_data !== ahblm_hrdata) begin n_fail++; $display("FAIL t3_data%0d: got %h want %h", k, req_data, ahblm_hrdata); end
      end
      @(negedge clk);
    end
    req_vld = '0;
  endtask

  task automatic test_wait_lock();
    do_reset();
    set_req(2, 1'b1, 32'h302, 2'd1); ahblm_hready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) set_req(3, 1'b1, 32'h400, 2'd2);
      ahblm_hready = (k == 2);
      #1;
      n_tests++; if (ahblm_htrans !== T_NSEQ || ahblm_haddr !== 32'h302 || ahblm_hsize !== 3'd1) begin
        n_fail++; $display("FAIL t4_lock%0d: got %h/%h/%h want %h/00000302/1", k, ahblm_htrans, ahblm_haddr, ahblm_hsize, T_NSEQ);
      end
      n_tests++; if (req_rdy !== 4'h0) begin n_fail++; $display("FAIL t4_nordy%0d: got %h want 0", k, req_rdy); end
      @(negedge clk);
    end
    ahblm_hrdata = 32'hCAFE_1234;
    #1;
    n_tests++; if (req_rdy !== 4'b0100 || req_data !== 32'h0000_CAFE) begin
      n_fail++; $display("FAIL t4_rdy2: got %h/%h want 4/0000cafe", req_rdy, req_data);
    end
    n_tests++; if (ahblm_haddr !== 32'h400 || ahblm_htrans !== T_NSEQ) begin
      n_fail++; $display("FAIL t4_p3: got %h/%h want 00000400/%h", ahblm_haddr, ahblm_htrans, T_NSEQ);
    end
    @(negedge clk);
    req_vld[2] = 1'b0; ahblm_hrdata = 32'h0BAD_F00D;
    #1;
    n_tests++; if (req_rdy !== 4'b1000 || req_data !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL t4_rdy3: got %h/%h want 8/0badf00d", req_rdy, req_data);
    end
    @(negedge clk);
    req_vld = '0;
  endtask

  task automatic test_error();
    do_reset();
    set_req(0, 1'b1, 32'h500, 2'd2); set_req(1, 1'b1, 32'h600, 2'd2);
    #1;
    n_tests++; if (ahblm_haddr !== 32'h500) begin n_fail++; $display("FAIL t5_p0: got %h want 00000500", ahblm_haddr); end
    @(negedge clk);
    ahblm_hresp = 1'b1; ahblm_hready = 1'b0;
    #1;
    n_tests++; if (ahblm_haddr !== 32'h600 || req_rdy !== 4'h0) begin
      n_fail++; $display("FAIL t5_err1: got %h/%h want 00000600/0", ahblm_haddr, req_rdy);
    end
    @(negedge clk);
    ahblm_hready = 1'b1; ahblm_hrdata = 32'hFFFF_FFFF;
    #1;
    n_tests++; if (req_rdy !== 4'b0001 || req_data !== 32'h0) begin
      n_fail++; $display("FAIL t5_err2: got %h/%h want 1/00000000", req_rdy, req_data);
    end
    @(negedge clk);
    req_vld[0] = 1'b0; ahblm_hresp = 1'b0; ahblm_hrdata = 32'h1234_5678;
    #1;
    n_tests++; if (req_rdy !== 4'b0010 || req_data !== 32'h1234_5678) begin
      n_fail++; $display("FAIL t5_p1: got %h/%h want 2/12345678", req_rdy, req_data);
    end
    @(negedge clk);
    req_vld = '0;
  endtask

  task automatic test_addr_change_reset();
    int rdy_seen = 0;
    do_reset();
    set_req(0, 1'b1, 32'h700, 2'd2);
    for (int k = 0; k < 5; k++) begin
      ahblm_hready = (k >= 2);
      if (k == 1 || k == 3) req_addr[31:0] = 32'h7F0 + 32'(k);
      if (k == 4) req_vld[0] = 1'b0;
      ahblm_hrdata = 32'h55AA_55AA;
      #1;
      if (req_rdy[0]) rdy_seen++;
      if (k < 3) begin
        n_tests++; if (ahblm_haddr !== 32'h700) begin n_fail++; $display("FAIL t6_haddr%0d: got %h want 00000700", k, ahblm_haddr); end
      end else if (k == 3) begin
        n_tests++; if (req_data !== 32'h55AA_55AA || ahblm_htrans !== T_IDLE) begin
          n_fail++; $display("FAIL t6_data: got %h/%h want 55aa55aa/%h", req_data, ahblm_htrans, T_IDLE);
        end
      end
      @(negedge clk);
    end
    n_tests++; if (rdy_seen != 1) begin n_fail++; $display("FAIL t6_rdy_once: got %0d want 1", rdy_seen); end
    set_req(1, 1'b1, 32'h800, 2'd2); ahblm_hready = 1'b1;
    #1;
    n_tests++; if (ahblm_haddr !== 32'h800) begin n_fail++; $display("FAIL t6_p1: got %h want 00000800", ahblm_haddr); end
    @(negedge clk);
    ahblm_hready = 1'b0;
    #1;
    rst_n = 1'b0; req_vld = '0;
    #1;
    n_tests++; if (ahblm_htrans !== T_IDLE || req_rdy !== 4'h0 || ahblm_haddr !== 32'h0) begin
      n_fail++; $display("FAIL t6_rst: got %h/%h/%h want %h/0/0", ahblm_htrans, req_rdy, ahblm_haddr, T_IDLE);
    end
    ahblm_hready = 1'b1;
    #1;
    n_tests++; if (req_rdy !== 4'h0) begin n_fail++; $display("FAIL t6_rst_rdy: got %h want 0", req_rdy); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] m_addr [N];
    logic [1:0]  m_size [N];
    bit          m_act  [N];
    int unsigned m_ptr = 0, m_hold_idx = 0, m_dph_idx = 0, exp_idx, p, busy;
    bit          m_hold = 0, m_dph = 0, err_pend = 0, exp_vld, issued;
    logic [31:0] m_dph_addr = '0, exp_addr, exp_data;
    logic [1:0]  m_dph_size = '0;
    logic [3:0]  exp_rdy;
    do_reset();
    for (int unsigned i = 0; i < N; i++) begin m_act[i] = 0; m_addr[i] = '0; m_size[i] = '0; end
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int unsigned i = 0; i < N; i++) begin
        issued = (m_hold && m_hold_idx == i) || (m_dph && m_dph_idx == i);
        if (!m_act[i] && cyc < 700 && $urandom_range(0, 2) == 0) begin
          m_act[i] = 1; m_addr[i] = $urandom; m_size[i] = 2'($urandom_range(0, 2));
        end
        req_vld[i] = m_act[i];
        req_size[i*2 +: 2] = m_size[i];
        req_addr[i*32 +: 32] = (issued && $urandom_range(0, 1) == 1) ? $urandom : m_addr[i];
      end
      // bus slave: random waits and occasional two-cycle error responses
      if (err_pend) begin
        ahblm_hresp = 1'b1; ahblm_hready = 1'b1; err_pend = 0;
      end else if (m_dph && $urandom_range(0, 7) == 0) begin
        ahblm_hresp = 1'b1; ahblm_hready = 1'b0; err_pend = 1;
      end else begin
        ahblm_hresp = 1'b0; ahblm_hready = ($urandom_range(0, 3) != 0);
      end
      ahblm_hrdata = m_dph ? mem_word(m_dph_addr & ~32'h3) : $urandom;

      exp_vld = 0; exp_idx = 0;
      if (m_hold) begin
        exp_vld = 1; exp_idx = m_hold_idx;
      end else begin
        for (int unsigned k = 0; k < N; k++) begin
          p = (m_ptr + k) % N;
          if (!exp_vld && m_act[p] && !(m_dph && m_dph_idx == p)) begin exp_vld = 1; exp_idx = p; end
        end
      end
      exp_addr = exp_vld ? align_addr(m_addr[exp_idx], m_size[exp_idx]) : 32'h0;
      exp_rdy  = (m_dph && ahblm_hready) ? 4'(1 << m_dph_idx) : 4'h0;
      exp_data = (m_dph && !ahblm_hresp) ? lane_extract(mem_word(m_dph_addr & ~32'h3), m_dph_addr, m_dph_size) : 32'h0;
      #1;
      n_tests++; if (ahblm_htrans !== (exp_vld ? T_NSEQ : T_IDLE) || ahblm_haddr !== exp_addr) begin
        n_fail++; $display("FAIL rand_aph c%0d: got %h/%h want %h/%h", cyc, ahblm_htrans, ahblm_haddr, exp_vld ? T_NSEQ : T_IDLE, exp_addr);
      end
      if (exp_vld) begin
        n_tests++; if (ahblm_hsize !== {1'b0, m_size[exp_idx]}) begin
          n_fail++; $display("FAIL rand_hsize c%0d: got %h want %h", cyc, ahblm_hsize, {1'b0, m_size[exp_idx]});
        end
      end
      n_tests++; if (req_rdy !== exp_rdy) begin n_fail++; $display("FAIL rand_rdy c%0d: got %h want %h", cyc, req_rdy, exp_rdy); end
      if (exp_rdy != 4'h0) begin
        n_tests++; if (req_data !== exp_data) begin n_fail++; $display("FAIL rand_data c%0d: got %h want %h", cyc, req_data, exp_data); end
      end
      @(posedge clk);
      if (m_dph && ahblm_hready) m_act[m_dph_idx] = 0;
      if (exp_vld && ahblm_hready) m_ptr = (exp_idx + 1) % N;
      if (ahblm_hready) begin
        m_dph = exp_vld;
        if (exp_vld) begin m_dph_idx = exp_idx; m_dph_addr = exp_addr; m_dph_size = m_size[exp_idx]; end
      end
      m_hold = exp_vld && !ahblm_hready;
      if (m_hold) m_hold_idx = exp_idx;
      @(negedge clk);
    end
    busy = 0;
    for (int unsigned i = 0; i < N; i++) busy += m_act[i];
    n_tests++; if (busy != 0) begin n_fail++; $display("FAIL rand_drain: got %0d outstanding want 0", busy); end
    req_vld = '0;
  endtask

  initial begin
    rst_n = 1'b0; req_vld = '0; req_addr = '0; req_size = '0;
    ahblm_hready = 1'b1; ahblm_hresp = 1'b0; ahblm_hrdata = 32'hFFFF_FFFF;
    test_reset();
    test_single_word();
    test_byte();
    test_all_four();
    test_wait_lock();
    test_error();
    test_addr_change_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
